// File: rtl/icache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_direct: direct-mapped, read-only instruction cache with line refill |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_direct #(
   parameter int INDEX_WIDTH    = 6,
   parameter int WORD_SEL_WIDTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rdy_to_fetch,
   input  logic [31:0] pc_2icache,
   output logic        instr_valid,
   output logic [31:0] instr_from_icache,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ans_valid,
   input  logic [31:0] mem_ans_data
);

   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int WORDS = 1 << WORD_SEL_WIDTH;
   localparam int OFF_W = WORD_SEL_WIDTH + 2;
   localparam int TAG_W = 32 - OFF_W - INDEX_WIDTH;
   localparam logic [WORD_SEL_WIDTH-1:0] LAST_WORD = '1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [WORD_SEL_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]               base_q, base_d;
   logic                      mem_req_q, mem_req_d;
   logic [31:0]               mem_addr_q, mem_addr_d;
   logic [LINES-1:0]          valid_q;
   logic [TAG_W-1:0]          tag_q  [LINES];
   logic [31:0]               data_q [LINES][WORDS];

   logic [TAG_W-1:0]          w_tag;
   logic [INDEX_WIDTH-1:0]    w_index;
   logic [WORD_SEL_WIDTH-1:0] w_word;
   logic [31:0]               w_pc_base;
   logic                      w_hit;
   logic [INDEX_WIDTH-1:0]    w_ref_index;
   logic [TAG_W-1:0]          w_ref_tag;
   logic [WORD_SEL_WIDTH-1:0] w_cnt_nxt;
   logic                      w_we;
   logic                      w_clr_valid;
   logic                      w_set_valid;
   logic                      w_unused;

   assign w_tag       = pc_2icache[31 -: TAG_W];
   assign w_index     = pc_2icache[OFF_W +: INDEX_WIDTH];
   assign w_word      = pc_2icache[2 +: WORD_SEL_WIDTH];
   assign w_pc_base   = {pc_2icache[31:OFF_W], {OFF_W{1'b0}}};
   assign w_unused    = ^pc_2icache[1:0];
   assign w_ref_index = base_q[OFF_W +: INDEX_WIDTH];
   assign w_ref_tag   = base_q[31 -: TAG_W];
   assign w_cnt_nxt   = cnt_q + 1'b1;

   assign w_hit             = valid_q[w_index] && (tag_q[w_index] == w_tag);
   assign instr_valid       = rdy && rdy_to_fetch && w_hit;
   assign instr_from_icache = instr_valid ? data_q[w_index][w_word] : 32'h0;
   assign mem_req           = mem_req_q;
   assign mem_addr          = mem_addr_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      w_we        = 1'b0;
      w_clr_valid = 1'b0;
      w_set_valid = 1'b0;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (rdy_to_fetch && !w_hit) begin
                  base_d     = w_pc_base;
                  cnt_d      = '0;
                  mem_req_d  = 1'b1;
                  mem_addr_d = w_pc_base;
                  state_d    = REFILL;
               end
            end
            REFILL: begin
               if (mem_ans_valid) begin
                  // Invalidate on the first word so a half-written line can never hit.
                  w_we        = 1'b1;
                  w_clr_valid = (cnt_q == '0);
                  cnt_d       = w_cnt_nxt;
                  if (cnt_q == LAST_WORD) begin
                     w_set_valid = 1'b1;
                     mem_req_d   = 1'b0;
                     mem_addr_d  = 32'h0;
                     state_d     = IDLE;
                  end else begin
                     mem_addr_d  = base_q + 32'({w_cnt_nxt, 2'b00});
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         base_q     <= 32'h0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'h0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         if (w_clr_valid) valid_q[w_ref_index] <= 1'b0;
         if (w_set_valid) valid_q[w_ref_index] <= 1'b1;
      end
   end

   // Tag and data contents need no reset; the valid bits alone gate hits.
   always_ff @(posedge clk) begin
      if (w_we)        data_q[w_ref_index][cnt_q] <= mem_ans_data;
      if (w_set_valid) tag_q[w_ref_index]         <= w_ref_tag;
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_icache_direct: randomized bench for icache_direct with a line-level model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_icache_direct;

   logic        clk = 1'b0;
   logic        rst, rdy, rdy_to_fetch, mem_ans_valid;
   logic [31:0] pc, mem_ans_data;
   logic        instr_valid, mem_req;
   logic [31:0] instr_from_icache, mem_addr;

   int total = 0;
   int bad   = 0;

   // Reference cache: one entry per line, indexed by pc[9:4], tag pc[31:10].
   logic        m_valid [64];
   logic [21:0] m_tag   [64];
   logic [31:0] m_data  [64][4];

   icache_direct dut (
      .clk               (clk),
      .rst               (rst),
      .rdy               (rdy),
      .rdy_to_fetch      (rdy_to_fetch),
      .pc_2icache        (pc),
      .instr_valid       (instr_valid),
      .instr_from_icache (instr_from_icache),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_ans_valid     (mem_ans_valid),
      .mem_ans_data      (mem_ans_data)
   );

   always #5 clk = ~clk;

   function automatic logic m_hit(input logic [31:0] a);
      return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
   endfunction

   function automatic logic exp_iv();
      return rdy && rdy_to_fetch && m_hit(pc);
   endfunction

   function automatic logic [31:0] exp_instr();
      return exp_iv() ? m_data[pc[9:4]][pc[3:2]] : 32'h0;
   endfunction

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
   endfunction

   // Plays the memory controller for one line refill; optional stall/drop points.
   task automatic serve(input logic [31:0] base, input logic [31:0] d [4], input int gaps_max,
                        input int stall_at, input int drop_at, input logic [31:0] hit_pc);
      logic [31:0] keep_pc;
      m_valid[base[9:4]] = 1'b0;
      for (int w = 0; w < 4; w++) begin
         repeat ($urandom_range(0, gaps_max)) begin
            @(negedge clk); mem_ans_valid = 1'b0; #1;
            total++;
            if (mem_req !== 1'b1 || mem_addr !== base + 32'(4 * w)) begin
               bad++; $display("FAIL gap_hold: req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, base + 32'(4 * w));
            end
            @(posedge clk);
         end
         if (w == stall_at) begin
            keep_pc = pc;
            @(negedge clk); mem_ans_valid = 1'b0; pc = hit_pc; #1;
            total++;
            if (instr_valid !== 1'b1 || instr_from_icache !== m_data[hit_pc[9:4]][hit_pc[3:2]]) begin
               bad++; $display("FAIL hit_during_refill: valid=%b instr=%h want valid=1 instr=%h",
                               instr_valid, instr_from_icache, m_data[hit_pc[9:4]][hit_pc[3:2]]);
            end
            @(posedge clk);
            repeat (3) begin
               @(negedge clk); rdy = 1'b0; #1;
               total++;
               if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== base + 32'(4 * w)) begin
                  bad++; $display("FAIL rdy_low_freeze: valid=%b req=%b addr=%h want valid=0 req=1 addr=%h",
                                  instr_valid, mem_req, mem_addr, base + 32'(4 * w));
               end
               @(posedge clk);
            end
            @(negedge clk); rdy = 1'b1; pc = keep_pc;
            @(posedge clk);
         end
         if (w == drop_at) begin
            @(negedge clk); mem_ans_valid = 1'b0; rdy_to_fetch = 1'b0; pc = 32'h0;
            @(posedge clk);
         end
         @(negedge clk); mem_ans_valid = 1'b0; #1;
         total++;
         if (mem_req !== 1'b1 || mem_addr !== base + 32'(4 * w)) begin
            bad++; $display("FAIL refill_addr w%0d: req=%b addr=%h want req=1 addr=%h", w, mem_req, mem_addr, base + 32'(4 * w));
         end
         mem_ans_valid = 1'b1; mem_ans_data = d[w];
         @(posedge clk);
      end
      @(negedge clk); mem_ans_valid = 1'b0;
      m_valid[base[9:4]] = 1'b1;
      m_tag[base[9:4]]   = base[31:10];
      for (int w = 0; w < 4; w++) m_data[base[9:4]][w] = d[w];
      #1;
      total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== exp_iv() || instr_from_icache !== exp_instr()) begin
         bad++; $display("FAIL refill_done: req=%b addr=%h valid=%b instr=%h want req=0 addr=0 valid=%b instr=%h",
                         mem_req, mem_addr, instr_valid, instr_from_icache, exp_iv(), exp_instr());
      end
   endtask

   task automatic mem_line(input logic [31:0] base, output logic [31:0] d [4]);
      for (int w = 0; w < 4; w++) d[w] = mem_val(base + 32'(4 * w));
   endtask

   task automatic start_miss(input logic [31:0] a);
      @(negedge clk); pc = a; rdy_to_fetch = 1'b1; #1;
      total++;
      if (instr_valid !== 1'b0 || instr_from_icache !== 32'h0) begin
         bad++; $display("FAIL miss_%h: valid=%b instr=%h want valid=0 instr=0", a, instr_valid, instr_from_icache);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || instr_from_icache !== 32'h0) begin
         bad++; $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h want all 0",
                         mem_req, mem_addr, instr_valid, instr_from_icache);
      end
      rst = 1'b0;
   endtask

   task automatic test_first_refill();
      logic [31:0] d [4];
      d = '{32'h11, 32'h22, 32'h33, 32'h44};
      serve(32'h0, d, 0, -1, -1, 32'h0);
      total++;
      if (instr_valid !== 1'b1 || instr_from_icache !== 32'h11) begin
         bad++; $display("FAIL first_hit: valid=%b instr=%h want valid=1 instr=00000011", instr_valid, instr_from_icache);
      end
   endtask

   task automatic test_hit();
      @(negedge clk); pc = 32'h8; #1;
      total++;
      if (instr_valid !== 1'b1 || instr_from_icache !== 32'h33 || mem_req !== 1'b0) begin
         bad++; $display("FAIL hit_word2: valid=%b instr=%h req=%b want valid=1 instr=00000033 req=0",
                         instr_valid, instr_from_icache, mem_req);
      end
      @(negedge clk); #1;
      total++;
      if (mem_req !== 1'b0) begin
         bad++; $display("FAIL hit_no_req: req=%b want 0", mem_req);
      end
   endtask

   task automatic test_evict();
      logic [31:0] d [4];
      start_miss(32'h400);
      mem_line(32'h400, d);
      serve(32'h400, d, 1, -1, -1, 32'h0);
      start_miss(32'h0);
      mem_line(32'h0, d);
      serve(32'h0, d, 1, -1, -1, 32'h0);
   endtask

   task automatic test_abandon();
      logic [31:0] d [4];
      start_miss(32'h100);
      mem_line(32'h100, d);
      serve(32'h100, d, 1, -1, 2, 32'h0);
      @(negedge clk); pc = 32'h104; rdy_to_fetch = 1'b1; #1;
      total++;
      if (instr_valid !== 1'b1 || instr_from_icache !== d[1] || mem_req !== 1'b0) begin
         bad++; $display("FAIL abandon_hit: valid=%b instr=%h req=%b want valid=1 instr=%h req=0",
                         instr_valid, instr_from_icache, mem_req, d[1]);
      end
      @(negedge clk); #1;
      total++;
      if (mem_req !== 1'b0) begin
         bad++; $display("FAIL abandon_no_req: req=%b want 0", mem_req);
      end
   endtask

   task automatic test_rdy_stall();
      logic [31:0] d [4];
      start_miss(32'h300);
      mem_line(32'h300, d);
      serve(32'h300, d, 1, 1, -1, 32'h4);
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] d [4];
      start_miss(32'h200);
      mem_line(32'h200, d);
      for (int w = 0; w < 2; w++) begin
         @(negedge clk); mem_ans_valid = 1'b0;
         mem_ans_valid = 1'b1; mem_ans_data = d[w];
         @(posedge clk);
      end
      @(negedge clk); mem_ans_valid = 1'b0; #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h208) begin
         bad++; $display("FAIL pre_reset: req=%b addr=%h want req=1 addr=00000208", mem_req, mem_addr);
      end
      rst = 1'b1; #1;
      total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL async_reset: req=%b addr=%h valid=%b want all 0", mem_req, mem_addr, instr_valid);
      end
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      #1 rst = 1'b0;
      serve(32'h200, d, 1, -1, -1, 32'h0);
   endtask

   task automatic test_random();
      logic [31:0] a, base;
      logic [31:0] d [4];
      for (int it = 0; it < 80; it++) begin
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
         @(negedge clk); pc = a; rdy_to_fetch = ($urandom_range(0, 3) != 0); #1;
         total++;
         if (instr_valid !== exp_iv() || instr_from_icache !== exp_instr() || mem_req !== 1'b0) begin
            bad++; $display("FAIL random_fetch %h: valid=%b instr=%h req=%b want valid=%b instr=%h req=0",
                            a, instr_valid, instr_from_icache, mem_req, exp_iv(), exp_instr());
         end
         if (rdy_to_fetch && !m_hit(a)) begin
            base = {a[31:4], 4'h0};
            mem_line(base, d);
            serve(base, d, 2, -1, -1, 32'h0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; rdy_to_fetch = 1'b1; pc = 32'h0;
      mem_ans_valid = 1'b0; mem_ans_data = 32'h0;
      test_reset();
      test_first_refill();
      test_hit();
      test_evict();
      test_abandon();
      test_rdy_stall();
      test_reset_mid_refill();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the memory controller.
- Serves fetch requests `rdy_to_fetch`/`pc_2icache` with a same-cycle hit response `instr_valid`/`instr_from_icache`.
- On a miss, runs a multi-word line refill from the memory controller through a request/answer handshake.
- Read-only. No write path, no coherence.

Parameters:
- INDEX_WIDTH, 6, log2 of line count (64 lines).
- WORD_SEL_WIDTH, 2, log2 of 32-bit words per line (4 words = 16 bytes).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- rdy  input  1  global ready; when low, all state is frozen
- rdy_to_fetch  input  1  fetcher request valid
- pc_2icache  input  32  fetch address; bits [1:0] ignored
- instr_valid  output  1  requested instruction returned this cycle
- instr_from_icache  output  32  returned instruction
- mem_req  output  1  refill word request, held until answered
- mem_addr  output  32  word-aligned refill address
- mem_ans_valid  input  1  one-cycle pulse: `mem_ans_data` holds the requested word
- mem_ans_data  input  32  refill data

Behaviour:
- Address split:
  - tag = pc[31:2+WORD_SEL_WIDTH+INDEX_WIDTH]
  - index = next INDEX_WIDTH bits
  - word = pc[2+WORD_SEL_WIDTH-1:2]
- Storage per line: valid bit, tag, 2^WORD_SEL_WIDTH data words.
- Hit is combinational: hit = valid[index] && tag match.
  - instr_valid = rdy_to_fetch && hit && rdy.
  - instr_from_icache = data[index][word] when instr_valid, else 0.
  - Zero-latency on hit.
- Reset (asynchronous, any state):
  - All valid bits cleared; FSM to IDLE; counter 0.
  - mem_req = 0, mem_addr = 0, instr_valid = 0, instr_from_icache = 0.
  - Data and tag contents are don't-care.
- FSM states IDLE and REFILL:
  - IDLE:
    - If rdy_to_fetch && !hit, latch the refill base = {pc tag, index, word 0, 2'b00} and clear the word counter.
    - mem_req <= 1, mem_addr <= base; go to REFILL.
  - REFILL, on mem_ans_valid:
    - Write mem_ans_data into word[counter] of the refill line.
    - If counter is not the last word: counter+1; mem_addr <= base + 4*(counter+1); mem_req stays 1.
    - If counter is the last word: write tag, set valid, mem_req <= 0, mem_addr <= 0; go to IDLE.
  - REFILL, without mem_ans_valid: hold all outputs.
- Line valid bit is cleared on the first refill write and set only after the last word, so a partially filled line never hits.
- Hit visibility after refill: the line becomes hittable in the first cycle after the final write (no same-cycle bypass). Refill latency is therefore 4 answers + 1 cycle.
- Request changes mid-refill:
  - The refill always completes for the latched address, even if `pc_2icache` changes or `rdy_to_fetch` drops (e.g. after a rollback).
  - After returning to IDLE, the current request is re-evaluated.
- Hits to other lines during REFILL are served normally.
- mem_ans_valid in IDLE is ignored.
- rdy low: FSM, counter, arrays and registered outputs are frozen; instr_valid is forced to 0. A mem_ans_valid arriving while rdy is low is not captured; the memory controller shares rdy and must not answer then.
- Counter wraps only through the IDLE transition; there is no overflow path.

Test Plan:
- Reset, then rdy_to_fetch=1, pc=0x00000000:
  - mem_req=1 with mem_addr=0x0, 0x4, 0x8, 0xC on successive answers (data 0x11,0x22,0x33,0x44).
  - instr_valid=1 with data 0x11 one cycle after the 4th answer.
- Then pc=0x00000008 → instr_valid=1 same cycle, instr=0x33, mem_req stays 0.
- pc=0x00000400 (same index, different tag) → miss, refill of 0x400..0x40C.
  - After refill, pc=0x0 misses again (eviction check).
- Start a refill at pc=0x100, then switch pc to 0x0 and drop rdy_to_fetch after the 2nd answer:
  - Refill of 0x100..0x10C still completes.
  - A later pc=0x104 hits with no mem_req.
- Assert rst mid-refill after 2 answers:
  - mem_req falls immediately.
  - Re-requesting the same pc issues a full 4-word refill from word 0.
- rdy=0 for 3 cycles during REFILL, with mem_ans_valid held low:
  - mem_addr and counter unchanged; instr_valid=0.
  - Refill resumes correctly when rdy=1.
